ora_misr: RTL and testbench
===========================

// Module: ora_misr
// PURPOSE
//   Output response analyser for the LBIST loop, sitting between the circuit under test and the
//   BIST controller. Compacts CUT response words into a MISR over a fixed window of patterns,
//   compares the signature with a golden value and pulses ora_res on mismatch.
//   ora_res feeds the controller's error counter and its TPG-restart / fail-increment OR gates.
//   The controller's TPG_RESET drives clr back into this block.
// PARAMETERS
//   DATA_W  8      CUT response / MISR width (>=2)
//   POLY    8'h1D  MISR feedback polynomial taps (DATA_W bits, x^DATA_W term implicit)
//   SEED    0      MISR value loaded at reset, on clr and at every window start
//   WINDOW  16     accepted beats per signature window (>=1)
//   CNT_W   8      width of the window counter
// PORTS
//   clk       in   1       rising-edge clock
//   rst_n     in   1       reset, asynchronous, active-low
//   clr       in   1       synchronous clear/hold (tie to controller TPG_RESET)
//   cut_valid in   1       response word valid
//   cut_ready out  1       block accepts a word this cycle
//   cut_data  in   DATA_W  CUT response word
//   golden    in   DATA_W  expected signature; sampled on the last-beat edge
//   ora_res   out  1       1-cycle mismatch pulse (to controller ORA_RES)
//   win_done  out  1       1-cycle pulse at every window end, pass or fail
//   sig_out   out  DATA_W  signature of the most recently completed window
//   win_cnt   out  CNT_W   completed windows since clear; saturates at all-ones
// BEHAVIOUR
//   - Reset (rst_n=0, async): state IDLE, misr=SEED, beat=0, ora_res=0, win_done=0,
//     sig_out=0, win_cnt=0, cut_ready=0.
//   - States:
//     IDLE   -> ACCUM when clr=0.
//     ACCUM  cut_ready=1. A beat is accepted when cut_valid&cut_ready.
//            On the WINDOW-th accepted beat, move to REPORT.
//     REPORT exactly 1 cycle. cut_ready=0, cut_valid ignored.
//            misr reloads SEED, beat=0, then -> ACCUM.
//   - MISR step on each accepted beat:
//     misr <= {misr[DATA_W-2:0],1'b0} ^ (misr[DATA_W-1] ? POLY : 0) ^ cut_data.
//   - On the last-beat edge: let nxt be the stepped value.
//     Registered, so visible during REPORT: sig_out<=nxt, win_done<=1,
//     ora_res<=(nxt!=golden), win_cnt<=sat_inc(win_cnt).
//     Latency: last beat accepted at edge N -> ora_res/win_done high for cycle N..N+1 only.
//   - beat counter: $clog2(WINDOW+1) bits, wraps only via the REPORT reload. No partial-window
//     compare ever occurs.
//   - clr=1 (any state, highest priority after rst_n):
//     next state IDLE, misr=SEED, beat=0, win_cnt=0, ora_res=0, win_done=0.
//     sig_out is retained. A beat presented in the same cycle is dropped.
//   - Controller feedback: an ora_res pulse raises TPG_RESET (clr) one cycle later.
//     This aborts the following window cleanly via the clr rule. No extra pulse, no lockup.
//   - WINDOW=1: every accepted beat yields a REPORT cycle. Max throughput is 1 word per 2 cycles.
//   - cut_valid low inside ACCUM: MISR and beat hold. Gaps are allowed.
// STRUCTURE
//   - Shared package bist_pkg: ora_state_t {IDLE, ACCUM, REPORT};
//     default polynomials per width (POLY_8=8'h1D, POLY_16=16'h002D);
//     sat_inc function reused by the controller error counter.
//   - One sub-module, misr_step: a pure combinational next-state function
//     (DATA_W, POLY), also used by the bench reference model.
//   - FSM, beat counter and output registers stay in ora_misr.
// TESTING (DATA_W=8, POLY=8'h1D, SEED=0 unless noted)
//   1 Reset/clr: rst_n=0 mid-window -> all outputs 0 immediately.
//     With clr=1 held, cut_ready stays 0. Release clr -> cut_ready=1 next cycle.
//   2 Pass, WINDOW=2: beats 0x01,0x02 with golden=0x00 -> sig_out=0x00, win_done=1, ora_res=0,
//     win_cnt=1, cut_ready=0 for exactly 1 cycle.
//   3 Feedback taps, WINDOW=2: beats 0x80,0x00 with golden=0x1D -> sig_out=0x1D, ora_res=0.
//     Same beats with golden=0x00 -> ora_res high exactly 1 cycle.
//   4 Gaps/back-pressure, WINDOW=4: valid toggled 1010... over 8 cycles -> signature equals
//     back-to-back case. Beats offered in the REPORT cycle are not consumed.
//   5 Loop with controller model (ora_res->clr after 1 cycle): mismatch window ->
//     single ora_res, win_cnt back to 0, next window restarts from SEED.
//   6 Saturation, CNT_W=2, WINDOW=1: 5 windows -> win_cnt sticks at 3, win_done pulses 5 times.
//     clr during the REPORT cycle -> ora_res cleared next cycle, state IDLE.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared LBIST definitions: ORA state encoding, default MISR polynomials
// and the saturating increment also used by the controller error counter.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } ora_state_t;

    localparam logic [7:0]  POLY_8  = 8'h1D;
    localparam logic [15:0] POLY_16 = 16'h002D;

    // Default feedback taps for a given MISR width (8-bit taps otherwise).
    function automatic logic [31:0] default_poly(input int width);
        if (width == 16) begin
            return {16'h0000, POLY_16};
        end
        return {24'h000000, POLY_8};
    endfunction

    // Increment that sticks at max_val instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input logic [31:0] max_val);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/misr_step.sv
// One MISR step: shift left, fold the outgoing MSB back through the
// polynomial taps and XOR in the new response word. Pure combinational.
module misr_step #(
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] POLY   = 8'h1D
) (
    input  logic [DATA_W-1:0] cur,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] nxt
);

    // Galois-style feedback: the x^DATA_W term is implicit in the shift-out.
    assign nxt = {cur[DATA_W-2:0], 1'b0}
               ^ (cur[DATA_W-1] ? POLY : {DATA_W{1'b0}})
               ^ data;

endmodule

// File: rtl/ora_misr.sv
// Output response analyser: compacts a fixed window of CUT response words
// into a MISR signature, compares it with the golden value and reports the
// outcome for one cycle. clr (controller TPG_RESET) aborts the window.
module ora_misr
    import bist_pkg::*;
#(
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] POLY   = DATA_W'(default_poly(DATA_W)),
    parameter logic [DATA_W-1:0] SEED   = '0,
    parameter int                WINDOW = 16,
    parameter int                CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              cut_valid,
    output logic              cut_ready,
    input  logic [DATA_W-1:0] cut_data,
    input  logic [DATA_W-1:0] golden,
    output logic              ora_res,
    output logic              win_done,
    output logic [DATA_W-1:0] sig_out,
    output logic [CNT_W-1:0]  win_cnt
);

    localparam int                BEAT_W    = $clog2(WINDOW + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WINDOW - 1);
    localparam logic [31:0]       CNT_MAX   = 32'({CNT_W{1'b1}});

    ora_state_t        state;
    logic [DATA_W-1:0] misr;
    logic [DATA_W-1:0] misr_nxt;
    logic [BEAT_W-1:0] beat;
    logic              accept;

    // cut_ready is high exactly while the FSM sits in ACCUM.
    assign accept = cut_valid & cut_ready;

    misr_step #(
        .DATA_W (DATA_W),
        .POLY   (POLY)
    ) u_step (
        .cur  (misr),
        .data (cut_data),
        .nxt  (misr_nxt)
    );

    // Window FSM, MISR, beat counter and registered report outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            misr      <= SEED;
            beat      <= '0;
            ora_res   <= 1'b0;
            win_done  <= 1'b0;
            sig_out   <= '0;
            win_cnt   <= '0;
            cut_ready <= 1'b0;
        end else if (clr) begin
            // Abort: any beat offered this cycle is dropped, sig_out survives.
            state     <= IDLE;
            misr      <= SEED;
            beat      <= '0;
            ora_res   <= 1'b0;
            win_done  <= 1'b0;
            win_cnt   <= '0;
            cut_ready <= 1'b0;
        end else begin
            ora_res  <= 1'b0;
            win_done <= 1'b0;
            case (state)
                IDLE: begin
                    state     <= ACCUM;
                    cut_ready <= 1'b1;
                end
                ACCUM: begin
                    if (accept) begin
                        misr <= misr_nxt;
                        beat <= beat + BEAT_W'(1);
                        if (beat == LAST_BEAT) begin
                            // Last beat: publish the stepped signature and verdict.
                            state     <= REPORT;
                            cut_ready <= 1'b0;
                            sig_out   <= misr_nxt;
                            win_done  <= 1'b1;
                            ora_res   <= (misr_nxt != golden);
                            win_cnt   <= CNT_W'(sat_inc(32'(win_cnt), CNT_MAX));
                        end
                    end
                end
                REPORT: begin
                    // Single report cycle; restart the next window from SEED.
                    misr      <= SEED;
                    beat      <= '0;
                    state     <= ACCUM;
                    cut_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    cut_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ora_misr.sv
// Bench for ora_misr: three instances (WINDOW=2, WINDOW=4, WINDOW=1/CNT_W=2)
// share clock, reset, clr, data and golden; each has its own cut_valid.
// Expected window reports are queued when a window is driven and popped
// when the instance raises win_done.
module tb_ora_misr;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr_tb = 1'b1;
    logic       loop_en = 1'b0;
    logic       ctrl_q;
    logic       clr;
    logic [7:0] cut_data = 8'h00;
    logic [7:0] golden = 8'h00;
    logic       v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
    logic       rdy0, rdy1, rdy2;
    logic       res0, res1, res2;
    logic       done0, done1, done2;
    logic [7:0] sig0, sig1, sig2;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;

    typedef struct packed {
        logic [7:0] sig;
        logic       res;
        logic [7:0] cnt;
    } exp_t;

    exp_t q0[$], q1[$], q2[$];
    int   cexp[3];
    int   cmax[3] = '{255, 255, 3};
    int   done_cnt[3];
    logic pd[3], pr[3];
    int   ora_pulses0 = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    // Controller model: ora_res is registered into TPG_RESET.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ctrl_q <= 1'b0;
        else        ctrl_q <= res0;
    end
    assign clr = clr_tb | (loop_en & ctrl_q);

    ora_misr #(.DATA_W(8), .POLY(8'h1D), .SEED(8'h00), .WINDOW(2), .CNT_W(8)) u_w2 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .cut_valid(v0), .cut_ready(rdy0),
        .cut_data(cut_data), .golden(golden), .ora_res(res0), .win_done(done0),
        .sig_out(sig0), .win_cnt(cnt0));

    ora_misr #(.DATA_W(8), .POLY(8'h1D), .SEED(8'h00), .WINDOW(4), .CNT_W(8)) u_w4 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .cut_valid(v1), .cut_ready(rdy1),
        .cut_data(cut_data), .golden(golden), .ora_res(res1), .win_done(done1),
        .sig_out(sig1), .win_cnt(cnt1));

    ora_misr #(.DATA_W(8), .POLY(8'h1D), .SEED(8'h00), .WINDOW(1), .CNT_W(2)) u_w1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .cut_valid(v2), .cut_ready(rdy2),
        .cut_data(cut_data), .golden(golden), .ora_res(res2), .win_done(done2),
        .sig_out(sig2), .win_cnt(cnt2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Independent reference of one MISR step (x^8 + x^4 + x^3 + x^2 + 1).
    function automatic logic [7:0] ref_step(input logic [7:0] m, input logic [7:0] d);
        return {m[6:0], 1'b0} ^ (m[7] ? 8'h1D : 8'h00) ^ d;
    endfunction

    task automatic mon(input int w, input logic done, input logic res,
                       input logic [7:0] sig, input logic [7:0] cnt, input logic rdy);
        exp_t e;
        int   sz;
        if (pd[w]) chk($sformatf("u%0d win_done width", w), 32'(done), 0);
        if (pr[w]) chk($sformatf("u%0d ora_res width", w), 32'(res), 0);
        if (w == 0 && res && !pr[0]) ora_pulses0++;
        if (done) begin
            done_cnt[w]++;
            case (w)
                0:       sz = q0.size();
                1:       sz = q1.size();
                default: sz = q2.size();
            endcase
            if (sz == 0) begin
                chk($sformatf("u%0d spurious win_done", w), 32'(done), 0);
            end else begin
                case (w)
                    0:       e = q0.pop_front();
                    1:       e = q1.pop_front();
                    default: e = q2.pop_front();
                endcase
                chk($sformatf("u%0d sig_out", w), 32'(sig), 32'(e.sig));
                chk($sformatf("u%0d ora_res", w), 32'(res), 32'(e.res));
                chk($sformatf("u%0d win_cnt", w), 32'(cnt), 32'(e.cnt));
                chk($sformatf("u%0d ready in report", w), 32'(rdy), 0);
            end
        end
        pd[w] = done;
        pr[w] = res;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                pd[i] = 1'b0;
                pr[i] = 1'b0;
            end
        end else begin
            mon(0, done0, res0, sig0, cnt0, rdy0);
            mon(1, done1, res1, sig1, cnt1, rdy1);
            mon(2, done2, res2, sig2, {6'b0, cnt2}, rdy2);
        end
    end

    task automatic setv(input int w, input logic val);
        case (w)
            0:       v0 = val;
            1:       v1 = val;
            default: v2 = val;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word and hold it until the instance accepts it.
    task automatic send(input int w, input logic [7:0] dat);
        logic acc;
        acc = 1'b0;
        cut_data = dat;
        setv(w, 1'b1);
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            case (w)
                0:       acc = rdy0;
                1:       acc = rdy1;
                default: acc = rdy2;
            endcase
            tick();
        end
        if (!acc) chk($sformatf("u%0d ready timeout", w), 32'(acc), 1);
    endtask

    task automatic run_win(input int w, input int n, input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3,
                           input logic [7:0] gold, input bit gap);
        logic [7:0] d[4];
        logic [7:0] m;
        exp_t       e;
        d = '{d0, d1, d2, d3};
        m = 8'h00;
        for (int i = 0; i < n; i++) m = ref_step(m, d[i]);
        cexp[w] = (cexp[w] >= cmax[w]) ? cmax[w] : cexp[w] + 1;
        e.sig = m;
        e.res = (m != gold);
        e.cnt = 8'(cexp[w]);
        case (w)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
        golden = gold;
        for (int i = 0; i < n; i++) begin
            send(w, d[i]);
            if (gap) begin
                setv(w, 1'b0);
                tick();
            end
        end
    endtask

    task automatic zero_counts();
        for (int i = 0; i < 3; i++) cexp[i] = 0;
    endtask

    task automatic do_clr();
        clr_tb = 1'b1;
        repeat (2) tick();
        clr_tb = 1'b0;
        zero_counts();
        repeat (2) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        zero_counts();
        for (int i = 0; i < 3; i++) done_cnt[i] = 0;

        // Reset values and clr hold
        repeat (2) tick();
        @(negedge clk);
        chk("reset cut_ready", 32'(rdy0), 0);
        chk("reset ora_res", 32'(res0), 0);
        chk("reset win_done", 32'(done0), 0);
        chk("reset sig_out", 32'(sig0), 0);
        chk("reset win_cnt", 32'(cnt0), 0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("ready while clr held", 32'(rdy0), 0);
        tick();
        clr_tb = 1'b0;
        @(negedge clk);
        chk("ready before first edge", 32'(rdy0), 0);
        tick();
        @(negedge clk);
        chk("ready after clr release", 32'(rdy0), 1);
        tick();

        // Pass window, WINDOW=2
        run_win(0, 2, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 1'b0);
        v0 = 1'b0;
        @(negedge clk);
        chk("ready low in report cycle", 32'(rdy0), 0);
        tick();
        @(negedge clk);
        chk("ready back after report", 32'(rdy0), 1);
        tick();

        // Feedback taps: pass then mismatch on the same beats
        run_win(0, 2, 8'h80, 8'h00, 8'h00, 8'h00, 8'h1D, 1'b0);
        run_win(0, 2, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        v0 = 1'b0;
        repeat (2) tick();

        // Asynchronous reset in the middle of a window
        send(0, 8'h55);
        v0 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst sig_out", 32'(sig0), 0);
        chk("async rst win_cnt", 32'(cnt0), 0);
        chk("async rst cut_ready", 32'(rdy0), 0);
        chk("async rst ora_res", 32'(res0), 0);
        zero_counts();
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // WINDOW=4: back-to-back across the report cycle, then gapped
        run_win(1, 4, 8'h3C, 8'hA5, 8'h81, 8'h7E, 8'h00, 1'b0);
        run_win(1, 4, 8'hF0, 8'h0F, 8'hC3, 8'h99, 8'h00, 1'b0);
        v1 = 1'b0;
        tick();
        run_win(1, 4, 8'h3C, 8'hA5, 8'h81, 8'h7E, 8'h00, 1'b1);
        v1 = 1'b0;
        repeat (3) tick();
        chk("u1 windows completed", 32'(done_cnt[1]), 3);

        // Controller loop: mismatch -> clr one cycle later
        ora_pulses0 = 0;
        loop_en = 1'b1;
        run_win(0, 2, 8'h01, 8'h02, 8'h00, 8'h00, 8'hFF, 1'b0);
        v0 = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        chk("loop win_cnt cleared", 32'(cnt0), 0);
        chk("loop single ora pulse", 32'(ora_pulses0), 1);
        zero_counts();
        tick();
        run_win(0, 2, 8'h80, 8'h00, 8'h00, 8'h00, 8'h1D, 1'b0);
        v0 = 1'b0;
        repeat (4) tick();
        chk("loop no extra pulse", 32'(ora_pulses0), 1);
        loop_en = 1'b0;

        // Saturation, WINDOW=1 / CNT_W=2
        do_clr();
        run_win(2, 1, 8'h11, 8'h00, 8'h00, 8'h00, 8'h11, 1'b0);
        run_win(2, 1, 8'h22, 8'h00, 8'h00, 8'h00, 8'h22, 1'b0);
        run_win(2, 1, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        run_win(2, 1, 8'h44, 8'h00, 8'h00, 8'h00, 8'h44, 1'b0);
        run_win(2, 1, 8'h55, 8'h00, 8'h00, 8'h00, 8'h55, 1'b0);
        v2 = 1'b0;
        repeat (2) tick();
        chk("u2 win_done pulses", 32'(done_cnt[2]), 5);
        chk("u2 win_cnt saturated", 32'(cnt2), 3);

        // clr during the report cycle
        run_win(2, 1, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        v2 = 1'b0;
        clr_tb = 1'b1;
        tick();
        @(negedge clk);
        chk("clr in report ora_res", 32'(res2), 0);
        chk("clr in report ready", 32'(rdy2), 0);
        chk("clr in report win_cnt", 32'(cnt2), 0);
        chk("clr keeps sig_out", 32'(sig2), 32'h0AA);
        zero_counts();
        tick();
        @(negedge clk);
        chk("idle while clr held", 32'(rdy2), 0);
        tick();
        clr_tb = 1'b0;
        tick();
        @(negedge clk);
        chk("ready after idle", 32'(rdy2), 1);
        tick();

        chk("u0 windows left", 32'(q0.size()), 0);
        chk("u1 windows left", 32'(q1.size()), 0);
        chk("u2 windows left", 32'(q2.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
